// File: rtl/alu_operand_stage_pkg.sv
// alu_operand_stage_pkg: shared widths, ALU opcodes, buffered-op record and forwarding helper
package alu_operand_stage_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int IMM_WIDTH  = 16;
  localparam int RADDR_W    = 5;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  typedef struct packed {
    logic [RADDR_W-1:0]    dst;
    logic [2:0]            aluop;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
  } op_t;
  function automatic logic [DATA_WIDTH-1:0] resolve_src(
    input logic [RADDR_W-1:0]    addr,
    input logic [DATA_WIDTH-1:0] rf_data,
    input logic                  ex_valid,
    input logic [RADDR_W-1:0]    ex_addr,
    input logic [DATA_WIDTH-1:0] ex_data,
    input logic                  mem_valid,
    input logic [RADDR_W-1:0]    mem_addr,
    input logic [DATA_WIDTH-1:0] mem_data
  );
    return addr == '0                      ? '0 :
           ex_valid  && ex_addr  == addr   ? ex_data :
           mem_valid && mem_addr == addr   ? mem_data : rf_data;
  endfunction
endpackage

// File: rtl/alu_operand_stage_resolve.sv
// operand_resolve: forwarding muxes for rs/rt plus immediate extension for operand B
module operand_resolve
  import alu_operand_stage_pkg::*;
(
  input  logic [RADDR_W-1:0]    rs_addr,
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic [RADDR_W-1:0]    rt_addr,
  input  logic [DATA_WIDTH-1:0] rt_data,
  input  logic [IMM_WIDTH-1:0]  imm,
  input  logic                  use_imm,
  input  logic                  imm_sext,
  input  logic                  fwd_ex_valid,
  input  logic [RADDR_W-1:0]    fwd_ex_addr,
  input  logic [DATA_WIDTH-1:0] fwd_ex_data,
  input  logic                  fwd_mem_valid,
  input  logic [RADDR_W-1:0]    fwd_mem_addr,
  input  logic [DATA_WIDTH-1:0] fwd_mem_data,
  output logic [DATA_WIDTH-1:0] a,
  output logic [DATA_WIDTH-1:0] b
);
  logic [DATA_WIDTH-1:0] rt_res;
  logic [DATA_WIDTH-1:0] imm_ext;
  always_comb begin
    a       = resolve_src(rs_addr, rs_data, fwd_ex_valid, fwd_ex_addr, fwd_ex_data,
                          fwd_mem_valid, fwd_mem_addr, fwd_mem_data);
    rt_res  = resolve_src(rt_addr, rt_data, fwd_ex_valid, fwd_ex_addr, fwd_ex_data,
                          fwd_mem_valid, fwd_mem_addr, fwd_mem_data);
    imm_ext = {{(DATA_WIDTH-IMM_WIDTH){imm_sext & imm[IMM_WIDTH-1]}}, imm};
    b       = use_imm ? imm_ext : rt_res;
  end
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: resolves operands at accept and buffers up to two ops (main + skid) ahead of the ALU
module alu_operand_stage
  import alu_operand_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_aluop,
  input  logic [RADDR_W-1:0]    in_rs_addr,
  input  logic [DATA_WIDTH-1:0] in_rs_data,
  input  logic [RADDR_W-1:0]    in_rt_addr,
  input  logic [DATA_WIDTH-1:0] in_rt_data,
  input  logic [IMM_WIDTH-1:0]  in_imm,
  input  logic                  in_use_imm,
  input  logic                  in_imm_sext,
  input  logic [RADDR_W-1:0]    in_dst_addr,
  input  logic                  fwd_ex_valid,
  input  logic [RADDR_W-1:0]    fwd_ex_addr,
  input  logic [DATA_WIDTH-1:0] fwd_ex_data,
  input  logic                  fwd_mem_valid,
  input  logic [RADDR_W-1:0]    fwd_mem_addr,
  input  logic [DATA_WIDTH-1:0] fwd_mem_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_A,
  output logic [DATA_WIDTH-1:0] out_B,
  output logic [2:0]            out_ALUop,
  output logic [RADDR_W-1:0]    out_dst_addr
);
  op_t main_op, skid_op, new_op;
  logic main_valid, skid_valid, accept;
  logic [DATA_WIDTH-1:0] a_res, b_res;
  operand_resolve u_resolve (
    .rs_addr(in_rs_addr), .rs_data(in_rs_data),
    .rt_addr(in_rt_addr), .rt_data(in_rt_data),
    .imm(in_imm), .use_imm(in_use_imm), .imm_sext(in_imm_sext),
    .fwd_ex_valid(fwd_ex_valid), .fwd_ex_addr(fwd_ex_addr), .fwd_ex_data(fwd_ex_data),
    .fwd_mem_valid(fwd_mem_valid), .fwd_mem_addr(fwd_mem_addr), .fwd_mem_data(fwd_mem_data),
    .a(a_res), .b(b_res)
  );
  always_comb begin
    new_op = '{dst: in_dst_addr, aluop: in_aluop, a: a_res, b: b_res};
    accept = in_valid & in_ready;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      main_op    <= '0;
      skid_op    <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || out_ready) begin
      main_valid <= skid_valid | accept;
      skid_valid <= 1'b0;
      if (skid_valid) main_op <= skid_op;
      else if (accept) main_op <= new_op;
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_op    <= new_op;
    end
  assign in_ready     = ~skid_valid;
  assign out_valid    = main_valid;
  assign out_A        = main_op.a;
  assign out_B        = main_op.b;
  assign out_ALUop    = main_op.aluop;
  assign out_dst_addr = main_op.dst;
endmodule
